// File: rtl/i2s_tx_pkg.sv
// Shared audio constants for the I2S serial stages: slot geometry, channel encoding
// and the width of the half-period bit counter.
package i2s_tx_pkg;

    localparam int SLOTBITS_DEF = 32;

    localparam logic LRCLK_LEFT  = 1'b0;
    localparam logic LRCLK_RIGHT = 1'b1;

    // The counter must reach SLOTBITS+1 so that an over-long half-period is distinguishable.
    function automatic int cnt_width(input int slotbits);
        return $clog2(slotbits + 2);
    endfunction

    localparam int CNT_W_DEF = cnt_width(SLOTBITS_DEF);

endpackage

// File: rtl/i2s_tx_if.sv
// Parallel stereo sample side and serial DAC side of the I2S transmitter.
interface i2s_tx_if #(
    parameter int BITSIZE = 16
);
    logic                      enable;
    logic                      lrclk;
    logic signed [BITSIZE-1:0] left;
    logic signed [BITSIZE-1:0] right;
    logic                      sdata;
    logic                      frame_strobe;
    logic                      frame_err;

    modport master (
        output enable, lrclk, left, right,
        input  sdata, frame_strobe, frame_err
    );

    modport slave (
        input  enable, lrclk, left, right,
        output sdata, frame_strobe, frame_err
    );

endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: latches a stereo pair per frame, shifts MSB-first on sdata from the lrclk edge cycle.
// MSB registered in the edge cycle, LSB BITSIZE-1 bclk later; no backpressure, free-running on bclk.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int BITSIZE  = 16,
    parameter int SLOTBITS = SLOTBITS_DEF
) (
    input  logic      bclk,
    input  logic      rst_n,
    i2s_tx_if.slave   bus
);

    localparam int            CW       = cnt_width(SLOTBITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_BITS = CW'(BITSIZE);
    localparam logic [CW-1:0] CNT_SLOT = CW'(SLOTBITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SLOTBITS + 1);

    logic               lrclk_d;
    logic               lr_edge;
    logic               armed;
    logic [CW-1:0]      cnt;
    logic [BITSIZE-1:0] shreg;
    logic [BITSIZE-1:0] held_right;
    logic [BITSIZE-1:0] load_word;

    assign lr_edge = (bus.lrclk != lrclk_d);

    // Left slot bypasses the hold register so its MSB leaves in the capture cycle.
    always_comb begin
        load_word = '0;
        if (bus.enable) begin
            load_word = (bus.lrclk == LRCLK_LEFT) ? bus.left : held_right;
        end
    end

    always_ff @(posedge bclk) begin
        if (!rst_n) begin
            lrclk_d          <= LRCLK_LEFT;
            armed            <= 1'b0;
            cnt              <= '0;
            shreg            <= '0;
            held_right       <= '0;
            bus.sdata        <= 1'b0;
            bus.frame_strobe <= 1'b0;
            bus.frame_err    <= 1'b0;
        end else begin
            lrclk_d          <= bus.lrclk;
            bus.frame_strobe <= 1'b0;
            if (lr_edge) begin
                // The first edge after reset only arms the check: the prior half is partial.
                if (armed && (cnt != CNT_SLOT)) begin
                    bus.frame_err <= 1'b1;
                end
                armed <= 1'b1;
                if (bus.lrclk == LRCLK_LEFT) begin
                    held_right       <= bus.right;
                    bus.frame_strobe <= 1'b1;
                end
                bus.sdata <= load_word[BITSIZE-1];
                shreg     <= load_word << 1;
                cnt       <= CNT_ONE;
            end else begin
                if (cnt < CNT_BITS) begin
                    bus.sdata <= shreg[BITSIZE-1];
                    shreg     <= shreg << 1;
                end else begin
                    bus.sdata <= 1'b0;
                end
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serial output stage sitting directly downstream of the audio effect cores (echo and similar), between the stereo effect chain and the codec DAC data pin.
- Captures a stereo pair of parallel signed samples once per frame and shifts them out MSB-first in standard I2S framing, with the one-bit delay, clocked from the codec bit clock.
- Also reports a per-frame strobe to upstream logic and a sticky framing-error flag when the lrclk half-period is not the expected slot width.

Parameters:
- BITSIZE, 16, sample width in bits; legal range 8..SLOTBITS.
- SLOTBITS, 32, bclk cycles per lrclk half-period (64 bclk per frame).

Ports:
- bclk  input  1  bit clock, sole clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  0 = transmit digital silence.
- lrclk  input  1  word select from codec master; 0 = left, 1 = right.
- left  input  BITSIZE  signed left sample, sampled only at frame start.
- right  input  BITSIZE  signed right sample, sampled only at frame start.
- sdata  output  1  serial DAC data, registered.
- frame_strobe  output  1  one-cycle pulse when a new stereo pair is latched.
- frame_err  output  1  sticky: half-period length mismatch detected.

Behaviour:
- Reset (rst_n = 0 at a rising edge): sdata = 0, frame_strobe = 0, frame_err = 0, shift register = 0, held pair = 0, bit counter = 0, lrclk_d = 0, armed = 0.
- Edge detect: lrclk_d registers lrclk every cycle; an edge is lrclk != lrclk_d. A falling edge starts the left slot and a rising edge starts the right slot.
- Frame latch: on a falling edge, capture left and right into the held pair and pulse frame_strobe for exactly that cycle. The right slot always transmits the right sample captured with its left partner, never a newer value.
- Slot load: on any edge, load the shift register with the held sample for the new channel. On a falling edge this is the value just captured from the left input (bypass). The MSB goes to sdata on the same edge.
  - The codec samples sdata on the next rising bclk, which gives the I2S one-bclk delay after the lrclk transition.
  - Reset the bit counter to 1.
- Shifting: on each non-edge cycle with bit counter < BITSIZE, sdata takes the next bit (MSB to LSB) and the counter increments. After BITSIZE bits, sdata = 0 for the rest of the slot (zero padding). The counter saturates at SLOTBITS+1.
- enable = 0: the shift register loads 0 instead of the sample, so sdata is all zeros. Framing, frame_strobe and error checking continue unchanged. Enable is sampled only at slot load; toggling it mid-slot does not corrupt the current word.
- Error check:
  - armed is set at the first edge after reset.
  - At each edge with armed = 1, the half-period length (bit counter value) must equal SLOTBITS; otherwise set frame_err.
  - frame_err clears only on reset.
  - The current slot still loads normally, so output self-resynchronises at the next edge.
- Reset mid-word: output goes to 0 on the next cycle. The first edge after reset restarts framing and no error is reported for the partial half-period.
- Latency: a sample present at a falling lrclk edge begins on sdata that same cycle. Its LSB appears BITSIZE-1 cycles later.

Decomposition:
- Shared audio package: default SLOTBITS (32), channel encoding constants LRCLK_LEFT = 0 and LRCLK_RIGHT = 1, and the bit-counter width derived from SLOTBITS.
- No sub-module needed.
- The edge detector plus half-period counter can be factored as i2s_framer if the future i2s_rx wants to share it. Keep it inline for now.

Test Plan:
- Nominal frame: BITSIZE=16, lrclk 32/32, left=16'hA5C3, right=16'h8001 -> starting at the falling-edge cycle, sdata = 1010010111000011 then 16 zeros; then from the rising edge 1000000000000001 then 16 zeros; frame_strobe high exactly 1 cycle per frame; frame_err = 0.
- Pair coherence: change right from 16'h1234 to 16'h7FFF mid-left-slot -> right slot transmits 16'h1234; 16'h7FFF is sent the following frame.
- enable=0 with left=16'hFFFF -> sdata all zeros; frame_strobe still pulses; enable raised mid-right-slot -> zeros until the next left slot, then 16'hFFFF.
- Short half-period: one right half of 30 bclk -> frame_err = 1 from that edge onward; next frame transmits correctly; frame_err stays 1 until rst_n pulse.
- Reset mid-word: assert rst_n=0 for 3 cycles at bit 7 of the left slot -> sdata = 0 within one cycle; the first edge afterwards starts a clean word; frame_err = 0.
- BITSIZE=24, SLOTBITS=32, left=24'h800000 -> 1 followed by 23 zeros, then 8 zeros of padding.
